// File: rtl/vc_rx_buffer.sv
// vc_rx_buffer: receive side of a router-to-router link, one per input port.
// Incoming flits land in per-VC circular FIFOs; per-VC on/off flow control,
// allocatable and empty status are returned as registered outputs, and the
// head flit of the selected VC is shown combinationally.
// Optional build macro: VC_RX_PROTOCOL_CHECK_EN enables packet-framing error
// detection into err_o plus simulation assertions on overflow/framing errors.

package noc_pkg;
    localparam int VC_NUM    = 2;
    localparam int VC_ID_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int PAYLOAD_W = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        flit_label_t          flit_label;
        logic [VC_ID_W-1:0]   vc_id;
        logic [PAYLOAD_W-1:0] payload;
    } flit_t;
endpackage

module vc_rx_buffer #(
    parameter int VC_NUM      = noc_pkg::VC_NUM,
    parameter int BUFFER_SIZE = 8,
    parameter int OFF_MARGIN  = 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  noc_pkg::flit_t                            data_i,
    input  logic                                      is_valid_i,
    output logic [VC_NUM-1:0]                         is_on_off_o,
    output logic [VC_NUM-1:0]                         is_allocatable_o,
    input  logic [((VC_NUM > 1) ? $clog2(VC_NUM) : 1)-1:0] rd_vc_i,
    input  logic                                      rd_en_i,
    output noc_pkg::flit_t                            head_flit_o,
    output logic [VC_NUM-1:0]                         vc_empty_o,
    output logic [VC_NUM-1:0]                         err_o
);
    import noc_pkg::*;

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = $clog2(BUFFER_SIZE + 1);

    typedef enum logic {ST_IDLE, ST_ACTIVE} vc_state_e;

    flit_t              mem_q    [VC_NUM][BUFFER_SIZE];
    logic [PTR_W-1:0]   rd_ptr_q [VC_NUM];
    logic [PTR_W-1:0]   rd_ptr_d [VC_NUM];
    logic [PTR_W-1:0]   wr_ptr_q [VC_NUM];
    logic [PTR_W-1:0]   wr_ptr_d [VC_NUM];
    logic [CNT_W-1:0]   cnt_q    [VC_NUM];
    logic [CNT_W-1:0]   cnt_d    [VC_NUM];
    vc_state_e          st_q     [VC_NUM];
    vc_state_e          st_d     [VC_NUM];

    logic [VC_NUM-1:0]  wr_acc;
    logic [VC_NUM-1:0]  rd_do;
    logic [VC_NUM-1:0]  ovf;
    logic [VC_NUM-1:0]  proto_err;
    logic [VC_NUM-1:0]  err_d;
    logic [VC_NUM-1:0]  on_off_q;
    logic [VC_NUM-1:0]  alloc_q;
    logic [VC_NUM-1:0]  empty_q;
    logic [VC_NUM-1:0]  err_q;

    // Pointer advance with explicit wrap so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(BUFFER_SIZE - 1)) return '0;
        return p + 1'b1;
    endfunction

    // Per-VC accept/pop decisions, next pointers, counts, states and errors.
    always_comb begin
        wr_acc    = '0;
        rd_do     = '0;
        ovf       = '0;
        proto_err = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            logic wr_hit;
            wr_hit   = is_valid_i && (int'(data_i.vc_id) == v);
            rd_do[v] = rd_en_i && (int'(rd_vc_i) == v) && (cnt_q[v] != '0);
            // A full VC still takes a flit when its head leaves this cycle.
            wr_acc[v] = wr_hit && ((cnt_q[v] < CNT_W'(BUFFER_SIZE)) || rd_do[v]);
            ovf[v]    = wr_hit && !wr_acc[v];

            cnt_d[v]    = cnt_q[v] + CNT_W'(wr_acc[v]) - CNT_W'(rd_do[v]);
            wr_ptr_d[v] = wr_acc[v] ? ptr_inc(wr_ptr_q[v]) : wr_ptr_q[v];
            rd_ptr_d[v] = rd_do[v]  ? ptr_inc(rd_ptr_q[v]) : rd_ptr_q[v];

            st_d[v] = st_q[v];
            if (wr_acc[v]) begin
`ifdef VC_RX_PROTOCOL_CHECK_EN
                // Misframed flits are stored but never move the state.
                if (st_q[v] == ST_IDLE) begin
                    if (data_i.flit_label == HEAD) st_d[v] = ST_ACTIVE;
                    else if (data_i.flit_label != HEADTAIL) proto_err[v] = 1'b1;
                end else begin
                    if (data_i.flit_label == TAIL) st_d[v] = ST_IDLE;
                    else if (data_i.flit_label != BODY) proto_err[v] = 1'b1;
                end
`else
                case (data_i.flit_label)
                    HEAD:           st_d[v] = ST_ACTIVE;
                    TAIL, HEADTAIL: st_d[v] = ST_IDLE;
                    default:        st_d[v] = st_q[v];
                endcase
`endif
            end
        end
        err_d = err_q | ovf | proto_err;
    end

    // Control state and registered status outputs, taken from post-update values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                rd_ptr_q[v] <= '0;
                wr_ptr_q[v] <= '0;
                cnt_q[v]    <= '0;
                st_q[v]     <= ST_IDLE;
            end
            on_off_q <= '1;
            alloc_q  <= '1;
            empty_q  <= '1;
            err_q    <= '0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                rd_ptr_q[v] <= rd_ptr_d[v];
                wr_ptr_q[v] <= wr_ptr_d[v];
                cnt_q[v]    <= cnt_d[v];
                st_q[v]     <= st_d[v];
                on_off_q[v] <= (cnt_d[v] < CNT_W'(BUFFER_SIZE - OFF_MARGIN));
                alloc_q[v]  <= (st_d[v] == ST_IDLE) && (cnt_d[v] == '0);
                empty_q[v]  <= (cnt_d[v] == '0);
            end
            err_q <= err_d;
        end
    end

    // Flit storage; not reset, since reset clears the pointers and counts.
    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_NUM; v++) begin
            if (wr_acc[v]) mem_q[v][wr_ptr_q[v]] <= data_i;
        end
    end

`ifdef VC_RX_PROTOCOL_CHECK_EN
    // Flag dropped flits and misframed packets during simulation.
    always @(posedge clk) begin
        if (!rst) begin
            assert (ovf == '0) else $warning("vc_rx_buffer: overflow on VCs %b", ovf);
            assert (proto_err == '0) else $warning("vc_rx_buffer: framing error on VCs %b", proto_err);
        end
    end
`endif

    assign head_flit_o      = mem_q[rd_vc_i][rd_ptr_q[rd_vc_i]];
    assign is_on_off_o      = on_off_q;
    assign is_allocatable_o = alloc_q;
    assign vc_empty_o       = empty_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_vc_rx_buffer.sv
// Self-checking bench for vc_rx_buffer (VC_NUM=2, BUFFER_SIZE=8, OFF_MARGIN=2):
// directed scenarios followed by random traffic, all checked against a
// queue-based reference model of the per-VC FIFOs and packet framing.
module tb_vc_rx_buffer;
    import noc_pkg::*;

    localparam int NVC = 2;
    localparam int BS  = 8;
    localparam int OM  = 2;

    logic            clk = 1'b0;
    logic            rst;
    flit_t           data_i;
    logic            is_valid_i;
    logic [NVC-1:0]  is_on_off_o;
    logic [NVC-1:0]  is_allocatable_o;
    logic [0:0]      rd_vc_i;
    logic            rd_en_i;
    flit_t           head_flit_o;
    logic [NVC-1:0]  vc_empty_o;
    logic [NVC-1:0]  err_o;

    vc_rx_buffer #(.VC_NUM(NVC), .BUFFER_SIZE(BS), .OFF_MARGIN(OM)) dut (
        .clk              (clk),
        .rst              (rst),
        .data_i           (data_i),
        .is_valid_i       (is_valid_i),
        .is_on_off_o      (is_on_off_o),
        .is_allocatable_o (is_allocatable_o),
        .rd_vc_i          (rd_vc_i),
        .rd_en_i          (rd_en_i),
        .head_flit_o      (head_flit_o),
        .vc_empty_o       (vc_empty_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per VC, packet-open flag, sticky error.
    flit_t    mq [NVC][$];
    bit       m_open [NVC];
    bit [1:0] m_err;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic flit_t mk(input flit_label_t l, input int vc, input int pl);
        flit_t f;
        f.flit_label = l;
        f.vc_id      = vc[0];
        f.payload    = pl[15:0];
        return f;
    endfunction

    task automatic model_clear();
        for (int v = 0; v < NVC; v++) begin
            mq[v].delete();
            m_open[v] = 1'b0;
        end
        m_err = '0;
    endtask

    task automatic model_step(input bit v, input flit_t f, input bit re, input int rv);
        bit pop, acc;
        int w;
        pop = re && (mq[rv].size() > 0);
        acc = 1'b0;
        w   = int'(f.vc_id);
        if (v) begin
            if (mq[w].size() < BS || (pop && rv == w)) acc = 1'b1;
            else m_err[w] = 1'b1;
        end
        if (pop) void'(mq[rv].pop_front());
        if (acc) begin
            mq[w].push_back(f);
`ifdef VC_RX_PROTOCOL_CHECK_EN
            if (!m_open[w]) begin
                if (f.flit_label == HEAD) m_open[w] = 1'b1;
                else if (f.flit_label != HEADTAIL) m_err[w] = 1'b1;
            end else begin
                if (f.flit_label == TAIL) m_open[w] = 1'b0;
                else if (f.flit_label != BODY) m_err[w] = 1'b1;
            end
`else
            if (f.flit_label == HEAD) m_open[w] = 1'b1;
            else if (f.flit_label == TAIL || f.flit_label == HEADTAIL) m_open[w] = 1'b0;
`endif
        end
    endtask

    task automatic check_all();
        logic [NVC-1:0] e_on, e_al, e_em;
        int rv;
        for (int v = 0; v < NVC; v++) begin
            e_on[v] = (mq[v].size() < BS - OM);
            e_al[v] = !m_open[v] && (mq[v].size() == 0);
            e_em[v] = (mq[v].size() == 0);
        end
        chk("on_off", 32'(is_on_off_o), 32'(e_on));
        chk("alloc",  32'(is_allocatable_o), 32'(e_al));
        chk("empty",  32'(vc_empty_o), 32'(e_em));
        chk("err",    32'(err_o), 32'(m_err));
        rv = int'(rd_vc_i);
        if (mq[rv].size() > 0) chk("head", 32'(head_flit_o), 32'(mq[rv][0]));
    endtask

    task automatic cyc(input bit v, input flit_t f, input bit re, input int rv);
        is_valid_i = v;
        data_i     = f;
        rd_en_i    = re;
        rd_vc_i    = rv[0];
        @(posedge clk);
        model_step(v, f, re, rv);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        is_valid_i = 1'b0;
        rd_en_i    = 1'b0;
        rd_vc_i    = '0;
        data_i     = '0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        chk("rst_on_off", 32'(is_on_off_o), 32'h3);
        chk("rst_alloc",  32'(is_allocatable_o), 32'h3);
        chk("rst_empty",  32'(vc_empty_o), 32'h3);
        chk("rst_err",    32'(err_o), 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        flit_t f;
        do_reset();

        // Single HEAD to VC0, visible as head flit next cycle.
        f = mk(HEAD, 0, 16'h0100);
        cyc(1, f, 0, 0);
        chk("t2_alloc", 32'(is_allocatable_o), 32'h2);
        chk("t2_empty", 32'(vc_empty_o), 32'h2);
        chk("t2_head",  32'(head_flit_o), 32'(f));

        // Fill to 6 -> off; pop one -> on again.
        for (int i = 1; i < 6; i++) cyc(1, mk(BODY, 0, 16'h0100 + i), 0, 0);
        chk("t3_off", 32'(is_on_off_o[0]), 32'h0);
        chk("t3_vc1", 32'(is_on_off_o[1]), 32'h1);
        cyc(0, '0, 1, 0);
        chk("t3_on", 32'(is_on_off_o[0]), 32'h1);

        // Refill to 8, then a 9th write with no read is dropped.
        for (int i = 0; i < 3; i++) cyc(1, mk(BODY, 0, 16'h0200 + i), 0, 0);
        cyc(1, mk(BODY, 0, 16'hDEAD), 0, 0);
        chk("t4_ovf_err", 32'(err_o[0]), 32'h1);
        for (int i = 0; i < 8; i++) cyc(0, '0, 1, 0);
        chk("t4_drained", 32'(vc_empty_o[0]), 32'h1);

        // Full VC with write and pop in the same cycle, through pointer wrap.
        do_reset();
        cyc(1, mk(HEAD, 0, 16'h0300), 0, 0);
        for (int i = 1; i < 8; i++) cyc(1, mk(BODY, 0, 16'h0300 + i), 0, 0);
        cyc(1, mk(BODY, 0, 16'h0308), 1, 0);
        chk("t4_no_err", 32'(err_o[0]), 32'h0);
        for (int i = 0; i < 8; i++) begin
            chk("t4_order", 32'(head_flit_o.payload), 32'h0301 + i);
            cyc(0, '0, 1, 0);
        end

        // Whole packet through VC1, then a lone HEADTAIL.
        do_reset();
        cyc(1, mk(HEAD, 1, 16'h0400), 0, 1);
        cyc(1, mk(BODY, 1, 16'h0401), 0, 1);
        cyc(1, mk(TAIL, 1, 16'h0402), 0, 1);
        chk("t5_busy", 32'(is_allocatable_o[1]), 32'h0);
        for (int i = 0; i < 3; i++) cyc(0, '0, 1, 1);
        chk("t5_free", 32'(is_allocatable_o[1]), 32'h1);
        cyc(1, mk(HEADTAIL, 1, 16'h0410), 0, 1);
        chk("t5_ht_busy", 32'(is_allocatable_o[1]), 32'h0);
        cyc(0, '0, 1, 1);
        chk("t5_ht_free", 32'(is_allocatable_o[1]), 32'h1);

        // BODY into an idle VC.
        cyc(1, mk(BODY, 0, 16'h0500), 0, 0);
`ifdef VC_RX_PROTOCOL_CHECK_EN
        chk("t6_err", 32'(err_o[0]), 32'h1);
`else
        chk("t6_err", 32'(err_o[0]), 32'h0);
`endif
        chk("t6_stored", 32'(vc_empty_o[0]), 32'h0);

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            f = mk(flit_label_t'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 65535));
            cyc($urandom_range(0, 99) < 55, f, $urandom_range(0, 99) < 60, $urandom_range(0, 1));
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/vc_rx_buffer.md
Name: vc_rx_buffer

Overview:
- Downstream (receiving) end of the router-to-router link, one instance per router input port.
- Accepts flits from the upstream router and stores them in per-VC circular FIFOs.
- Returns per-VC on/off flow control and VC-allocatable status to the upstream router.
- Presents the head flit of any selected VC to the local router pipeline (route computation / VC allocation / switch allocation).

Parameters:
- VC_NUM, noc_pkg::VC_NUM, number of virtual channels.
- BUFFER_SIZE, 8, flit slots per VC; must be ≥ OFF_MARGIN+1.
- OFF_MARGIN, 2, free-slot margin at which a VC is switched off; covers the round trip of a registered on/off signal.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- data_i  input  flit_t  incoming flit. Uses fields flit_label (HEAD/BODY/TAIL/HEADTAIL) and vc_id.
- is_valid_i  input  1  data_i valid this cycle.
- is_on_off_o  output  VC_NUM  per VC: 1 = upstream may send, 0 = stop.
- is_allocatable_o  output  VC_NUM  per VC: 1 = VC idle and empty, free for a new packet.
- rd_vc_i  input  $clog2(VC_NUM)  VC selected for read and head view.
- rd_en_i  input  1  pop the head flit of rd_vc_i.
- head_flit_o  output  flit_t  head flit of VC rd_vc_i (show-ahead, combinational).
- vc_empty_o  output  VC_NUM  per VC: FIFO empty.
- err_o  output  VC_NUM  sticky per-VC error flags.

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-high on rst.
- Reset values:
  - all read/write pointers = 0; counts = 0; VC states = IDLE.
  - is_on_off_o = all 1; is_allocatable_o = all 1; vc_empty_o = all 1; err_o = 0.
  - Reset mid-packet discards all buffered flits.
- Storage:
  - Per-VC circular FIFO of BUFFER_SIZE entries.
  - Pointers are $clog2(BUFFER_SIZE) bits and wrap from BUFFER_SIZE-1 to 0; wrap-around for non-power-of-2 sizes is explicit.
  - count[v] is $clog2(BUFFER_SIZE+1) bits.
- Write:
  - When is_valid_i=1, the flit goes to VC data_i.vc_id.
  - Accepted if count < BUFFER_SIZE, or if the same VC is read in the same cycle.
  - Otherwise the flit is dropped and an overflow is flagged.
- Read:
  - rd_en_i=1 pops the head of VC rd_vc_i.
  - rd_en_i on an empty VC is ignored.
  - head_flit_o is undefined (don't-care) while the selected VC is empty.
- Simultaneous read and write, same VC: count unchanged, both pointers advance.
- VC state machine, per VC:
  - IDLE → ACTIVE on an accepted HEAD.
  - ACTIVE → IDLE on an accepted TAIL.
  - HEADTAIL leaves the state at IDLE.
  - BODY/TAIL in IDLE, or HEAD/HEADTAIL in ACTIVE, is a protocol error. The flit is still stored and the state is not changed.
- is_on_off_o[v]:
  - Registered, computed from the post-update count.
  - 0 when count ≥ BUFFER_SIZE−OFF_MARGIN, else 1.
  - Becomes visible one cycle after the causing write or read.
- is_allocatable_o[v]: registered; 1 when the post-update state is IDLE and the post-update count is 0.
- vc_empty_o[v]: registered from the post-update count.
- err_o[v]: set on overflow (always) or on a protocol error (see the optional feature). Sticky until rst.

Optional Feature:
- Macro: VC_RX_PROTOCOL_CHECK_EN.
- Defined:
  - Protocol errors as defined above set err_o[v].
  - Simulation assertions fire on overflow and on protocol errors.
- Undefined:
  - No protocol-error detection; the state machine simply follows the labels.
  - err_o reports overflow only.
  - No assertions.

Test Plan:
All scenarios use VC_NUM=2, BUFFER_SIZE=8, OFF_MARGIN=2.
1. Reset: assert rst for 2 cycles → is_on_off_o=2'b11, is_allocatable_o=2'b11, vc_empty_o=2'b11, err_o=2'b00.
2. HEAD to VC0 → next cycle: is_allocatable_o=2'b10, vc_empty_o=2'b10; with rd_vc_i=0, head_flit_o equals the written flit.
3. Write 6 flits to VC0 with no reads → cycle after the 6th: is_on_off_o[0]=0. Pop 1 (count 5) → next cycle is_on_off_o[0]=1. VC1 stays 1 throughout.
4. Fill VC0 to 8 flits:
   - 9th write with no read → dropped, err_o[0]=1, count stays 8, FIFO contents unchanged.
   - After a fresh reset and refill to 8, a 9th write with a simultaneous pop → accepted, count stays 8, FIFO order preserved including wrap-around.
5. HEAD, BODY, TAIL to VC1, then pop 3 → is_allocatable_o[1]=1 one cycle after the last pop. A single HEADTAIL, once popped, likewise returns is_allocatable_o to 1.
6. BODY to idle VC0 → err_o[0]=1 when VC_RX_PROTOCOL_CHECK_EN is defined; err_o[0]=0 when it is undefined. Flit is stored in both builds.
